ddr_cas_data_responder: RTL and testbench

- DRAM-side counterpart of the controller's CAS-to-data burst sequencer.
- Accepts CAS read/write commands, holds them in an in-order pending queue with per-entry latency countdowns, and runs one data burst per command exactly RL (read) or WL (write) cycles after acceptance.
  - Read bursts are driven from an internal model memory.
  - Write bursts are captured into that memory.
- Sits in the DDR4 memory model, opposite the controller data path, on clock_t.

---
 rtl/ddr_cas_data_responder_pkg.sv | 29 ++
 rtl/ddr_cas_data_responder_cas_pending_queue.sv | 70 +++++++
 rtl/ddr_cas_data_responder.sv | 125 ++++++++++++
 tb/tb_ddr_cas_data_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cas_data_responder_pkg.sv
// Shared types for the DRAM-side CAS data responder: rw encoding, FSM states, queue entry.
// Latency: none (types only).
// Backpressure: none (types only).
package ddr_cas_data_responder_pkg;

  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;

  // Queue entries carry fixed-width fields; the top narrows them to its own ADDR_W.
  localparam int CAS_ADDR_W = 16;
  localparam int CAS_DUE_W  = 8;

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_READ_BURST,
    RESP_WRITE_BURST
  } resp_fsm_type;

  typedef struct packed {
    logic [1:0]            rw;
    logic [CAS_ADDR_W-1:0] addr;
    logic [CAS_DUE_W-1:0]  due;
  } cas_entry_t;

  function automatic logic is_legal_rw(input logic [1:0] rw);
    return (rw == READ) || (rw == WRITE);
  endfunction

endpackage

// File: rtl/ddr_cas_data_responder_cas_pending_queue.sv
// In-order pending CAS queue; every entry's due counter decrements each cycle, saturating at 0.
// Latency: a push is visible at head the cycle after its edge; pop removes head at the edge.
// Backpressure: caller pushes only while count < QDEPTH; push and pop may coincide.
module cas_pending_queue
  import ddr_cas_data_responder_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic             clock_t,
  input  logic             reset,
  input  logic             push,
  input  cas_entry_t       push_entry,
  input  logic             pop,
  output cas_entry_t       head,
  output logic             head_late,
  output logic [CNT_W-1:0] count
);

  cas_entry_t       ent_q  [QDEPTH];
  cas_entry_t       ent_d  [QDEPTH];
  logic             late_q [QDEPTH];
  logic             late_d [QDEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wr_idx;

  // An entry is late once it has sat at due == 0 across an edge without being popped.
  always_comb begin
    wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (pop && (i < QDEPTH - 1)) begin
        ent_d[i]  = ent_q[(i + 1) % QDEPTH];
        late_d[i] = late_q[(i + 1) % QDEPTH];
      end else begin
        ent_d[i]  = ent_q[i];
        late_d[i] = late_q[i];
      end
      late_d[i] = late_d[i] | (ent_d[i].due == '0);
      if (ent_d[i].due != '0) ent_d[i].due = ent_d[i].due - CAS_DUE_W'(1);
      if (push && (CNT_W'(i) == wr_idx)) begin
        ent_d[i]  = push_entry;
        late_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock_t) begin
    for (int i = 0; i < QDEPTH; i++) begin
      ent_q[i]  <= ent_d[i];
      late_q[i] <= late_d[i];
    end
  end

  assign head      = ent_q[0];
  assign head_late = late_q[0];
  assign count     = cnt_q;

endmodule

// File: rtl/ddr_cas_data_responder.sv
// DRAM-side CAS responder: queues READ/WRITE commands and runs one BL-beat burst per command.
// Latency: first beat RL (read) / WL (write) cycles after acceptance; late starts flag timing_err.
// Backpressure: cas_ready drops while QDEPTH commands are pending; bursts are strictly in order.
module ddr_cas_data_responder
  import ddr_cas_data_responder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int BL     = 8,
  parameter int RL     = 11,
  parameter int WL     = 9,
  parameter int QDEPTH = 4
) (
  input  logic              clock_t,
  input  logic              reset,
  input  logic              cas_valid,
  input  logic [1:0]        cas_rw,
  input  logic [ADDR_W-1:0] cas_addr,
  output logic              cas_ready,
  input  logic [DATA_W-1:0] wr_dq,
  output logic [DATA_W-1:0] rd_dq,
  output logic              rd_dq_valid,
  output logic              wr_capture,
  output logic              data_busy,
  output logic              timing_err,
  output logic              cas_err
);

  localparam int LOG2BL = $clog2(BL);
  localparam int CNT_W  = $clog2(QDEPTH + 1);

  resp_fsm_type      state_q, state_d;
  logic [LOG2BL-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cur_addr, nxt_addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  cas_entry_t       push_entry, q_head;
  logic             q_late, push, start, last_beat, illegal_acc, cas_err_pend;
  logic [CNT_W-1:0] q_count;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LOG2BL-1:0] idx);
    return {base[ADDR_W-1:LOG2BL], base[LOG2BL-1:0] + idx};
  endfunction

  assign cas_ready   = q_count < CNT_W'(QDEPTH);
  assign push        = cas_valid && cas_ready && is_legal_rw(cas_rw);
  assign illegal_acc = cas_valid && cas_ready && !is_legal_rw(cas_rw);

  always_comb begin
    push_entry      = '0;
    push_entry.rw   = cas_rw;
    push_entry.addr = CAS_ADDR_W'(cas_addr);
    push_entry.due  = (cas_rw == WRITE) ? CAS_DUE_W'(WL - 1) : CAS_DUE_W'(RL - 1);
  end

  cas_pending_queue #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_queue (
    .clock_t    (clock_t),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (start),
    .head       (q_head),
    .head_late  (q_late),
    .count      (q_count)
  );

  generate
    if (ADDR_W < CAS_ADDR_W) begin : g_addr_pad
      logic unused_head_addr;
      assign unused_head_addr = ^q_head.addr[CAS_ADDR_W-1:ADDR_W];
    end
  endgenerate

  // A due head starts from IDLE or straight off the last beat, giving seamless bursts.
  always_comb begin
    last_beat = (state_q != RESP_IDLE) && (beat_q == LOG2BL'(BL - 1));
    start     = ((state_q == RESP_IDLE) || last_beat) && (q_count != '0) && (q_head.due == '0);
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    if (state_q != RESP_IDLE) beat_d = beat_q + LOG2BL'(1);
    if (start) begin
      state_d = (q_head.rw == WRITE) ? RESP_WRITE_BURST : RESP_READ_BURST;
      beat_d  = '0;
      base_d  = q_head.addr[ADDR_W-1:0];
    end else if (last_beat) begin
      state_d = RESP_IDLE;
    end
  end

  assign cur_addr    = beat_addr(base_q, beat_q);
  assign nxt_addr    = beat_addr(base_d, beat_d);
  assign rd_dq_valid = (state_q == RESP_READ_BURST);
  assign wr_capture  = (state_q == RESP_WRITE_BURST);
  assign data_busy   = (state_q != RESP_IDLE);

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q      <= RESP_IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      rd_dq        <= '0;
      timing_err   <= 1'b0;
      cas_err_pend <= 1'b0;
      cas_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      timing_err   <= start && q_late;
      cas_err_pend <= illegal_acc;
      cas_err      <= cas_err_pend;
      // Forward the write landing this edge so a following read sees it immediately.
      if (state_d == RESP_READ_BURST)
        rd_dq <= (wr_capture && (cur_addr == nxt_addr)) ? wr_dq : mem[nxt_addr];
    end
  end

  always_ff @(posedge clock_t) begin
    if (wr_capture) mem[cur_addr] <= wr_dq;
  end

endmodule

// File: tb/tb_ddr_cas_data_responder.sv
// Bench for ddr_cas_data_responder: directed steps plus random traffic, checked each cycle
// against a schedule model (start = max(accept + latency, bus free)) and a shadow memory.
module tb_ddr_cas_data_responder;
  import ddr_cas_data_responder_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;
  localparam int BL     = 8;
  localparam int RL     = 11;
  localparam int WL     = 9;
  localparam int QDEPTH = 4;

  logic              clock_t   = 1'b0;
  logic              reset     = 1'b1;
  logic              cas_valid = 1'b0;
  logic [1:0]        cas_rw    = 2'b00;
  logic [ADDR_W-1:0] cas_addr  = '0;
  logic [DATA_W-1:0] wr_dq     = '0;
  logic              cas_ready, rd_dq_valid, wr_capture, data_busy, timing_err, cas_err;
  logic [DATA_W-1:0] rd_dq;

  always #5 clock_t = ~clock_t;

  ddr_cas_data_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BL(BL), .RL(RL), .WL(WL), .QDEPTH(QDEPTH)
  ) dut (
    .clock_t     (clock_t),
    .reset       (reset),
    .cas_valid   (cas_valid),
    .cas_rw      (cas_rw),
    .cas_addr    (cas_addr),
    .cas_ready   (cas_ready),
    .wr_dq       (wr_dq),
    .rd_dq       (rd_dq),
    .rd_dq_valid (rd_dq_valid),
    .wr_capture  (wr_capture),
    .data_busy   (data_busy),
    .timing_err  (timing_err),
    .cas_err     (cas_err)
  );

  typedef struct {
    logic [1:0] rw;
    int         addr;
    int         t_acc;
    int         start;
    bit         late;
  } cmd_t;

  cmd_t        cmds[$];
  logic [63:0] mmem [1024];
  logic [63:0] last_rd  = '0;
  int          edge_n   = 0;
  int          bus_free = 0;
  int          err_at   = -1;
  int          w_addr   = 0;
  int          cur_beat = -1;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          n_total  = 0;
  bit          chk_en   = 0;
  bit          m_ready  = 1;
  bit          pat_mode = 0;
  bit          w_pend   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int active_cmd(input int c);
    foreach (cmds[k]) if (c >= cmds[k].start && c < cmds[k].start + BL) return k;
    return -1;
  endfunction

  function automatic int pending(input int c);
    int n = 0;
    foreach (cmds[k]) if (cmds[k].t_acc <= c && cmds[k].start > c) n++;
    return n;
  endfunction

  // One clock: apply the edge to the model, then check the cycle that follows it.
  task automatic tick();
    int k, i, a, lat, due, st;
    bit e_v, e_w, e_b, e_t;
    @(posedge clock_t);
    edge_n++;
    if (w_pend) mmem[w_addr] = wr_dq;
    w_pend = 0;
    if (reset) begin
      for (int j = cmds.size() - 1; j >= 0; j--)
        if (cmds[j].start + BL > edge_n) cmds.delete(j);
      bus_free = edge_n;
      err_at   = -1;
      last_rd  = '0;
      chk_en   = 1;
    end else if (cas_valid && m_ready) begin
      if (cas_rw == READ || cas_rw == WRITE) begin
        lat = (cas_rw == READ) ? RL : WL;
        due = edge_n + lat;
        st  = (due > bus_free) ? due : bus_free;
        cmds.push_back('{cas_rw, int'(cas_addr), edge_n, st, st > due});
        bus_free = st + BL;
      end else begin
        err_at = edge_n + 1;
      end
    end
    #1;
    i = 0; e_v = 0; e_w = 0; e_b = 0; e_t = 0; cur_beat = -1;
    if (chk_en) begin
      k = active_cmd(edge_n);
      if (k >= 0) begin
        i = edge_n - cmds[k].start;
        a = (cmds[k].addr & ~(BL - 1)) | ((cmds[k].addr + i) & (BL - 1));
        e_b = 1;
        e_t = cmds[k].late && (i == 0);
        cur_beat = i;
        if (cmds[k].rw == READ) begin
          e_v = 1;
          last_rd = mmem[a];
        end else begin
          e_w = 1;
          w_pend = 1;
          w_addr = a;
        end
      end
      m_ready = pending(edge_n) < QDEPTH;
      check("rd_dq_valid", 64'(rd_dq_valid), 64'(e_v));
      check("wr_capture",  64'(wr_capture),  64'(e_w));
      check("data_busy",   64'(data_busy),   64'(e_b));
      check("timing_err",  64'(timing_err),  64'(e_t));
      check("cas_err",     64'(cas_err),     64'(err_at == edge_n));
      check("cas_ready",   64'(cas_ready),   64'(m_ready));
      check("rd_dq",       rd_dq,            last_rd);
    end
    wr_dq = (e_w && pat_mode) ? 64'(32'hA0 + i) : {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic issue(input logic [1:0] rw, input int a);
    cas_valid = 1'b1;
    cas_rw    = rw;
    cas_addr  = ADDR_W'(a);
    tick();
    cas_valid = 1'b0;
  endtask

  initial begin
    int r, guard;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    // Write a pattern block, read it back in order, then read with a wrapping start.
    pat_mode = 1;
    issue(WRITE, 'h010);
    idle(30);
    issue(READ, 'h010);
    idle(20);
    issue(READ, 'h015);
    idle(20);

    // Reads 8 cycles apart run seamlessly and on time.
    issue(READ, 'h010);
    idle(7);
    issue(READ, 'h011);
    idle(30);

    // WRITE right behind a READ is due early and starts late.
    issue(READ, 'h012);
    issue(WRITE, 'h018);
    idle(40);
    pat_mode = 0;

    // Five attempts in a row against a 4-deep queue.
    cas_valid = 1'b1;
    cas_rw    = READ;
    for (int j = 0; j < 5; j++) begin
      cas_addr = ADDR_W'('h010 + j);
      tick();
    end
    cas_valid = 1'b0;
    idle(60);

    // Illegal encodings raise cas_err and queue nothing.
    issue(2'b11, 'h010);
    idle(3);
    issue(2'b00, 'h010);
    idle(5);

    // Reset during beat 3 of a read with two more reads queued.
    issue(READ, 'h010);
    issue(READ, 'h013);
    issue(READ, 'h016);
    guard = 0;
    while (cur_beat != 3 && guard < 40) begin
      tick();
      guard++;
    end
    check("wait_beat3", 64'(cur_beat == 3), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(40);

    // Fill 0x000..0x03F with random data, then random mixed traffic over that range.
    for (int b = 0; b < 8; b++) begin
      issue(WRITE, b * BL);
      idle(7);
    end
    idle(30);
    for (int j = 0; j < 400; j++) begin
      r         = $urandom_range(0, 19);
      cas_valid = ($urandom_range(0, 2) == 0);
      cas_rw    = (r < 10) ? READ : (r < 19) ? WRITE : 2'b11;
      cas_addr  = ADDR_W'($urandom_range(0, 63));
      tick();
    end
    cas_valid = 1'b0;
    idle(120);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
